// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU sequencing controller.
//   - opcode encodings of the 2-bit op field
//   - bit positions of the instruction fields
//   - FSM state encoding (localparams plus the enum built on them)
package cpu_pkg;

  localparam int INSTR_W = 8;

  // Opcodes, instr[7:6]
  localparam logic [1:0] OP_IN  = 2'b00;
  localparam logic [1:0] OP_OUT = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  // Instruction field slices: op | src | dst, with the jump target overlaying src|dst
  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int SRC_HI = 5;
  localparam int SRC_LO = 3;
  localparam int DST_HI = 2;
  localparam int DST_LO = 0;
  localparam int TGT_HI = 5;
  localparam int TGT_LO = 0;

  // State encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_LOAD  = S_LOAD,
    ST_FETCH = S_FETCH,
    ST_WAIT  = S_WAIT,
    ST_EXEC  = S_EXEC
  } cpu_state_e;

endpackage

// File: rtl/cpu_decode.sv
// cpu_decode: purely combinational instruction decoder.
//   instr    : instruction register contents
//   rf_we    : IN or MOV writes the register file
//   rf_wsel  : 1 = write data from register-file read port (MOV), 0 = data_in
//   rf_waddr : dst field
//   rf_raddr : src field
//   out_we   : OUT loads the output register
//   is_jmp   : JMP
//   jmp_tgt  : instr[5:0] resized (zero-extend or truncate) to ADDR_W
// The strobes are raw decodes; the sequencer qualifies them with its EXEC state.
module cpu_decode
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [INSTR_W-1:0] instr,
  output logic               rf_we,
  output logic               rf_wsel,
  output logic [2:0]         rf_waddr,
  output logic [2:0]         rf_raddr,
  output logic               out_we,
  output logic               is_jmp,
  output logic [ADDR_W-1:0]  jmp_tgt
);

  logic [1:0] op;

  assign op       = instr[OP_HI:OP_LO];
  assign rf_raddr = instr[SRC_HI:SRC_LO];
  assign rf_waddr = instr[DST_HI:DST_LO];
  assign jmp_tgt  = ADDR_W'(instr[TGT_HI:TGT_LO]);

  always_comb begin
    rf_we   = 1'b0;
    rf_wsel = 1'b0;
    out_we  = 1'b0;
    is_jmp  = 1'b0;
    case (op)
      OP_IN:  rf_we = 1'b1;
      OP_MOV: begin
        rf_we   = 1'b1;
        rf_wsel = 1'b1;
      end
      OP_OUT: out_we = 1'b1;
      OP_JMP: is_jmp = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: program-load / fetch-decode-execute sequencer for the 8-bit CPU.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-low reset
//   ram_we            : host load request, one word per cycle on ram_data_in
//   ram_data_in       : instruction word to store while loading
//   pc_recount        : one-cycle pulse, (re)start execution at address 0
//   ram_rdata         : synchronous RAM read data
//   ram_addr/ram_wr/ram_wdata/ram_rd : RAM port
//   rf_we/rf_waddr/rf_raddr/rf_wsel  : register-file controls
//   out_we            : output-register load (datapath loads reg[rf_raddr])
//   running           : high in FETCH, WAIT and EXEC
//
// All inputs are sampled on the rising edge and act on the following cycle.
// Every output is a decode of registered state, so outputs are 0 as soon as
// rst falls and never follow an input combinationally.
//
// RAM read contract: ram_rd is high for the FETCH cycle with ram_addr=pc; the
// RAM returns the word on ram_rdata during the next (WAIT) cycle and it is
// captured into ir at the end of that cycle. There is no back-pressure.
//
// Loading: a sampled ram_we=1 puts the FSM in LOAD for the next cycle, which
// issues ram_wr with the captured word at load_addr. A fresh entry into LOAD
// writes address 0; each further sampled ram_we advances load_addr (mod depth).
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_we,
  input  logic [DATA_W-1:0] ram_data_in,
  input  logic              pc_recount,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rd,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [2:0]        rf_raddr,
  output logic              rf_wsel,
  output logic              out_we,
  output logic              running
);

  cpu_state_e        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] wdata_q;

  logic              dec_rf_we;
  logic              dec_rf_wsel;
  logic [2:0]        dec_rf_waddr;
  logic [2:0]        dec_rf_raddr;
  logic              dec_out_we;
  logic              dec_is_jmp;
  logic [ADDR_W-1:0] dec_jmp_tgt;

  cpu_decode #(.ADDR_W(ADDR_W)) u_decode (
    .instr    (ir),
    .rf_we    (dec_rf_we),
    .rf_wsel  (dec_rf_wsel),
    .rf_waddr (dec_rf_waddr),
    .rf_raddr (dec_rf_raddr),
    .out_we   (dec_out_we),
    .is_jmp   (dec_is_jmp),
    .jmp_tgt  (dec_jmp_tgt)
  );

  // Priority everywhere: ram_we, then pc_recount, then the normal transition.
  // Leaving FETCH/WAIT through either override drops the in-flight
  // instruction before it reaches EXEC, so its strobes never appear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      load_addr <= '0;
      ir        <= '0;
      wdata_q   <= '0;
    end else if (ram_we) begin
      state     <= ST_LOAD;
      pc        <= '0;
      wdata_q   <= ram_data_in;
      load_addr <= (state == ST_LOAD) ? load_addr + 1'b1 : '0;
    end else if (pc_recount) begin
      state <= ST_FETCH;
      pc    <= '0;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_IDLE;
        ST_LOAD:  state <= ST_IDLE;
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          ir    <= ram_rdata;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          pc    <= dec_is_jmp ? dec_jmp_tgt : pc + 1'b1;
          state <= ST_FETCH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM side
  assign ram_wr    = (state == ST_LOAD);
  assign ram_rd    = (state == ST_FETCH);
  assign ram_addr  = (state == ST_LOAD) ? load_addr : pc;
  assign ram_wdata = wdata_q;
  assign running   = (state == ST_FETCH) || (state == ST_WAIT) || (state == ST_EXEC);

  // Strobes only in EXEC; address/select fields follow ir, which changes only
  // on entry to EXEC, so they hold their last value in every other state.
  assign rf_we    = (state == ST_EXEC) && dec_rf_we;
  assign out_we   = (state == ST_EXEC) && dec_out_we;
  assign rf_wsel  = dec_rf_wsel;
  assign rf_waddr = dec_rf_waddr;
  assign rf_raddr = dec_rf_raddr;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed plus randomized bench for cpu_seq_ctrl.
// A program-level model (program image, pc, phase within a 3-cycle
// instruction) predicts the outputs; a compare process checks them on every
// falling edge. A simple synchronous RAM model serves the DUT's RAM port.
module tb_cpu_seq_ctrl;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk;
  logic              rst;
  logic              ram_we;
  logic [7:0]        ram_data_in;
  logic              pc_recount;
  logic [7:0]        ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_wdata;
  logic              ram_rd;
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [2:0]        rf_raddr;
  logic              rf_wsel;
  logic              out_we;
  logic              running;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] ram   [DEPTH];
  logic [7:0] m_mem [DEPTH];
  bit         m_load_active;
  bit         m_run;
  int         m_phase;
  int         m_pc;
  int         m_laddr;
  logic [7:0] m_wdata;

  logic [13:0] wr_log[$];
  logic [5:0]  rd_log[$];

  cpu_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ram_we      (ram_we),
    .ram_data_in (ram_data_in),
    .pc_recount  (pc_recount),
    .ram_rdata   (ram_rdata),
    .ram_addr    (ram_addr),
    .ram_wr      (ram_wr),
    .ram_wdata   (ram_wdata),
    .ram_rd      (ram_rd),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_raddr    (rf_raddr),
    .rf_wsel     (rf_wsel),
    .out_we      (out_we),
    .running     (running)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]   = 8'h00;
      m_mem[i] = 8'h00;
    end
    ram_rdata <= 8'h00;
    forever begin
      @(posedge clk);
      if (ram_wr) ram[ram_addr] = ram_wdata;
      if (ram_rd) ram_rdata <= ram[ram_addr];
    end
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_load_active = 1'b0;
    m_run         = 1'b0;
    m_phase       = 0;
    m_pc          = 0;
    m_laddr       = 0;
    m_wdata       = 8'h00;
  endtask

  task automatic model_step();
    logic [7:0] ins;
    if (ram_we) begin
      m_laddr        = m_load_active ? (m_laddr + 1) % DEPTH : 0;
      m_mem[m_laddr] = ram_data_in;
      m_wdata        = ram_data_in;
      m_load_active  = 1'b1;
      m_run          = 1'b0;
      m_phase        = 0;
      m_pc           = 0;
    end else if (pc_recount) begin
      m_load_active = 1'b0;
      m_run         = 1'b1;
      m_phase       = 0;
      m_pc          = 0;
    end else begin
      m_load_active = 1'b0;
      if (m_run) begin
        if (m_phase == 2) begin
          ins     = m_mem[m_pc];
          m_pc    = (ins[7:6] == 2'b11) ? int'(ins[5:0]) : (m_pc + 1) % DEPTH;
          m_phase = 0;
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit         exp_rd;
    bit         exec;
    logic [7:0] ins;
    logic [1:0] op;
    if (!rst) begin
      chk("rst_ram_wr",   ram_wr,    0);
      chk("rst_ram_rd",   ram_rd,    0);
      chk("rst_ram_addr", ram_addr,  0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_rf_we",    rf_we,     0);
      chk("rst_rf_wsel",  rf_wsel,   0);
      chk("rst_rf_waddr", rf_waddr,  0);
      chk("rst_rf_raddr", rf_raddr,  0);
      chk("rst_out_we",   out_we,    0);
      chk("rst_running",  running,   0);
    end else begin
      if (ram_wr === 1'b1) wr_log.push_back({ram_addr, ram_wdata});
      if (ram_rd === 1'b1) rd_log.push_back(ram_addr);
      chk("ram_wr", ram_wr, m_load_active);
      if (m_load_active) begin
        chk("wr_addr", ram_addr, m_laddr);
        chk("wr_data", ram_wdata, m_wdata);
      end
      exp_rd = m_run && (m_phase == 0);
      chk("ram_rd", ram_rd, exp_rd);
      if (exp_rd) chk("rd_addr", ram_addr, m_pc);
      chk("running", running, m_run);
      exec = m_run && (m_phase == 2);
      ins  = m_mem[m_pc];
      op   = ins[7:6];
      chk("rf_we",  rf_we,  exec && (op == 2'b00 || op == 2'b10));
      chk("out_we", out_we, exec && (op == 2'b01));
      if (exec) begin
        case (op)
          2'b00: begin
            chk("in_waddr", rf_waddr, ins[2:0]);
            chk("in_wsel",  rf_wsel,  0);
          end
          2'b10: begin
            chk("mov_waddr", rf_waddr, ins[2:0]);
            chk("mov_raddr", rf_raddr, ins[5:3]);
            chk("mov_wsel",  rf_wsel,  1);
          end
          2'b01: chk("out_raddr", rf_raddr, ins[5:3]);
          default: ;
        endcase
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    compare();
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_word(input logic [7:0] d);
    ram_we      = 1'b1;
    ram_data_in = d;
    tick();
  endtask

  task automatic end_load();
    ram_we = 1'b0;
    tick();
  endtask

  task automatic pulse_recount();
    pc_recount = 1'b1;
    tick();
    pc_recount = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] exp5[5];
    logic [7:0] last_w;
    int         n;
    int         cyc;

    exp5 = '{8'h38, 8'h81, 8'hC3, 8'h00, 8'hC4};

    rst         = 1'b0;
    ram_we      = 1'b0;
    ram_data_in = 8'h00;
    pc_recount  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Load five words
    for (int i = 0; i < 5; i++) load_word(exp5[i]);
    end_load();
    @(negedge clk);
    chk("load5_idle_wr",  ram_wr,  0);
    chk("load5_idle_run", running, 0);
    chk("load5_count", wr_log.size(), 5);
    if (wr_log.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("load5_addr", wr_log[i][13:8], i);
        chk("load5_data", wr_log[i][7:0], exp5[i]);
      end
    end

    // Run IN / MOV / OUT / JMP
    tick();
    load_word(8'h38);
    load_word(8'h81);
    load_word(8'h48);
    load_word(8'hC0);
    end_load();
    pulse_recount();
    @(negedge clk);
    chk("run_fetch0_rd",   ram_rd,   1);
    chk("run_fetch0_addr", ram_addr, 0);
    wait_neg(2);
    chk("run_in_we",    rf_we,    1);
    chk("run_in_wsel",  rf_wsel,  0);
    chk("run_in_waddr", rf_waddr, 0);
    wait_neg(3);
    chk("run_mov_we",    rf_we,    1);
    chk("run_mov_wsel",  rf_wsel,  1);
    chk("run_mov_raddr", rf_raddr, 0);
    chk("run_mov_waddr", rf_waddr, 1);
    wait_neg(3);
    chk("run_out_we",    out_we,   1);
    chk("run_out_rfwe",  rf_we,    0);
    chk("run_out_raddr", rf_raddr, 1);
    wait_neg(3);
    chk("run_jmp_rfwe",  rf_we,    0);
    chk("run_jmp_outwe", out_we,   0);
    wait_neg(1);
    chk("run_jmp_rd",   ram_rd,   1);
    chk("run_jmp_addr", ram_addr, 0);

    // Restart during WAIT of the MOV at address 1
    repeat (4) @(posedge clk);
    #1;
    pulse_recount();
    @(negedge clk);
    chk("restart_rfwe", rf_we,    0);
    chk("restart_rd",   ram_rd,   1);
    chk("restart_addr", ram_addr, 0);
    wait_neg(2);
    chk("restart_in_we",    rf_we,    1);
    chk("restart_in_waddr", rf_waddr, 0);

    // Collision: ram_we and pc_recount together
    tick();
    ram_we      = 1'b1;
    pc_recount  = 1'b1;
    ram_data_in = 8'h55;
    tick();
    ram_we     = 1'b0;
    pc_recount = 1'b0;
    @(negedge clk);
    chk("coll_wr",   ram_wr,    1);
    chk("coll_addr", ram_addr,  0);
    chk("coll_data", ram_wdata, 8'h55);
    chk("coll_rd",   ram_rd,    0);
    tick();

    // Wrap: 65 IN words, last overwrites address 0; then run pc 63 -> 0
    wr_log.delete();
    last_w = 8'h00;
    for (int i = 0; i < DEPTH + 1; i++) begin
      last_w = {2'b00, 6'($urandom_range(0, 63))};
      load_word(last_w);
    end
    end_load();
    chk("wrap_count", wr_log.size(), DEPTH + 1);
    if (wr_log.size() == DEPTH + 1) begin
      chk("wrap_last_addr", wr_log[DEPTH][13:8], 0);
      chk("wrap_last_data", wr_log[DEPTH][7:0], last_w);
    end
    rd_log.delete();
    pulse_recount();
    wait_neg(200);
    chk("wrap_rd_count", rd_log.size() >= DEPTH + 1, 1);
    if (rd_log.size() >= DEPTH + 1) begin
      chk("wrap_pc63", rd_log[DEPTH-1], 63);
      chk("wrap_pc0",  rd_log[DEPTH],   0);
    end

    // Reset in the middle of a load
    tick();
    load_word(8'($urandom));
    load_word(8'($urandom));
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_wr",   ram_wr,   0);
    chk("midrst_addr", ram_addr, 0);
    chk("midrst_run",  running,  0);
    chk("midrst_rfwe", rf_we,    0);
    @(posedge clk);
    #1 ram_we = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("postrst_wr",   ram_wr,   0);
    chk("postrst_rd",   ram_rd,   0);
    chk("postrst_run",  running,  0);
    chk("postrst_addr", ram_addr, 0);
    tick();

    // Randomized load/run rounds
    for (int r = 0; r < 15; r++) begin
      n = $urandom_range(1, 70);
      for (int i = 0; i < n; i++) load_word(8'($urandom));
      end_load();
      pulse_recount();
      cyc = $urandom_range(30, 200);
      for (int c = 0; c < cyc; c++) begin
        pc_recount  = ($urandom_range(0, 39) == 0);
        ram_we      = ($urandom_range(0, 99) == 0);
        ram_data_in = 8'($urandom);
        tick();
      end
      ram_we     = 1'b0;
      pc_recount = 1'b0;
      tick();
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
